// File: rtl/serial_comparator_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state encoding,
// compare result encoding and the decode from result to output flags.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_result_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_flags_t;

    // One-hot flag decode; an illegal encoding yields no flag at all.
    function automatic cmp_flags_t decode_result(input cmp_result_t res);
        cmp_flags_t f;
        case (res)
            CMP_LT:  f = '{gt: 1'b0, lt: 1'b1, eq: 1'b0};
            CMP_EQ:  f = '{gt: 1'b0, lt: 1'b0, eq: 1'b1};
            CMP_GT:  f = '{gt: 1'b1, lt: 1'b0, eq: 1'b0};
            default: f = '{gt: 1'b0, lt: 1'b0, eq: 1'b0};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/serial_comparator_if.sv
// Request/result bundle of the serial comparator. The master side issues
// start with the operands; the slave side (the comparator) returns status
// and the three result flags.
interface serial_comparator_if #(
    parameter int SIZE = 8
);
    logic            start;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            busy;
    logic            done;
    logic            a_gt_b;
    logic            a_lt_b;
    logic            a_eq_b;

    modport master (
        output start, a, b,
        input  busy, done, a_gt_b, a_lt_b, a_eq_b
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_gt_b, a_lt_b, a_eq_b
    );
endinterface

// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit per clock.
// Operands are captured on an accepted start (IDLE or DONE); the result
// flags are published together with a one-cycle done strobe.
// Build option: CMP_EARLY_EXIT_EN -- when defined, COMPARE stops at the first
// differing bit; otherwise every compare takes SIZE bit cycles (constant time)
// and only the highest difference is remembered.
module serial_comparator
    import cmp_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_comparator_if.slave bus
);

    localparam int K_W = $clog2(SIZE);
    localparam logic [K_W-1:0] K_TOP  = K_W'(SIZE - 1);
    localparam logic [K_W-1:0] K_ZERO = {K_W{1'b0}};
    localparam logic [K_W-1:0] K_ONE  = {{(K_W-1){1'b0}}, 1'b1};

    state_t          state_r;
    logic [SIZE-1:0] ra_r;
    logic [SIZE-1:0] rb_r;
    logic [K_W-1:0]  k_r;
    logic            diff_r;     // a difference has already been seen
    logic            gt_r;       // A's bit at that first difference
    logic            busy_r;
    logic            done_r;
    cmp_flags_t      flags_r;

    logic            bit_diff_s;
    logic            last_bit_s;
    logic            term_s;
    logic            accept_s;
    cmp_result_t     result_s;

    // Per-bit compare, termination decision and the result it would publish.
    always_comb begin
        bit_diff_s = ra_r[k_r] ^ rb_r[k_r];
        last_bit_s = (k_r == K_ZERO);
`ifdef CMP_EARLY_EXIT_EN
        term_s     = bit_diff_s | last_bit_s;
`else
        term_s     = last_bit_s;
`endif
        // The highest difference wins: an earlier latched one takes priority
        // over the bit under test.
        if (diff_r) begin
            result_s = gt_r ? CMP_GT : CMP_LT;
        end else if (bit_diff_s) begin
            result_s = ra_r[k_r] ? CMP_GT : CMP_LT;
        end else begin
            result_s = CMP_EQ;
        end
        accept_s = bus.start && ((state_r == IDLE) || (state_r == DONE));
    end

    // Sequencer: operand capture, bit walk, difference latch and result publish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ra_r    <= {SIZE{1'b0}};
            rb_r    <= {SIZE{1'b0}};
            k_r     <= K_ZERO;
            diff_r  <= 1'b0;
            gt_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            flags_r <= '{gt: 1'b0, lt: 1'b0, eq: 1'b0};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        ra_r    <= bus.a;
                        rb_r    <= bus.b;
                        k_r     <= K_TOP;
                        diff_r  <= 1'b0;
                        gt_r    <= 1'b0;
                        flags_r <= '{gt: 1'b0, lt: 1'b0, eq: 1'b0};
                        busy_r  <= 1'b1;
                        state_r <= COMPARE;
                    end else begin
                        // Flags are left untouched so the last result stays visible.
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                COMPARE: begin
                    if (bit_diff_s && !diff_r) begin
                        diff_r <= 1'b1;
                        gt_r   <= ra_r[k_r];
                    end
                    if (term_s) begin
                        flags_r <= decode_result(result_s);
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        k_r     <= k_r - K_ONE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.a_gt_b = flags_r.gt;
    assign bus.a_lt_b = flags_r.lt;
    assign bus.a_eq_b = flags_r.eq;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator (SIZE=8): a vector table of operand
// pairs with hand-computed flags and latencies, plus hand-written sequences
// for start-during-compare, back-to-back start and reset mid-compare.
module tb_serial_comparator;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    serial_comparator_if #(.SIZE(8)) bus ();

    serial_comparator #(.SIZE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags packed as {gt, lt, eq}; lat_early is the early-exit latency
    // (SIZE - m + 1, m = highest differing bit); constant-time latency is 9.
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] flags;
        int         lat_early;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int lat_early);
`ifdef CMP_EARLY_EXIT_EN
        return lat_early;
`else
        return (lat_early > 0) ? 9 : 0;
`endif
    endfunction

    function automatic logic [2:0] flags_now();
        return {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b};
    endfunction

    // Drive start with operands for exactly one rising edge (the accept edge).
    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges (accept edge = 1) until done is seen, bounded.
    task automatic wait_done(output int edges, output int bcnt);
        edges = 1;
        bcnt  = bus.busy ? 1 : 0;
        while (!bus.done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.busy) bcnt++;
        end
    endtask

    initial begin
        int e;
        int bc;
        int done_seen;
        errors = 0;
        checks = 0;

        vecs[0] = '{8'h80, 8'h7F, 3'b100, 2};
        vecs[1] = '{8'h12, 8'h13, 3'b010, 9};
        vecs[2] = '{8'hA5, 8'hA5, 3'b001, 9};
        vecs[3] = '{8'hC0, 8'h80, 3'b100, 3};
        vecs[4] = '{8'hC1, 8'h80, 3'b100, 3};
        vecs[5] = '{8'h00, 8'hFF, 3'b010, 2};
        vecs[6] = '{8'hFF, 8'hFF, 3'b001, 9};
        vecs[7] = '{8'h3C, 8'h34, 3'b100, 6};
        vecs[8] = '{8'h01, 8'h00, 3'b100, 9};
        vecs[9] = '{8'h00, 8'h00, 3'b001, 9};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        #3;
        chk("reset_outputs", {27'd0, bus.busy, bus.done, flags_now()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_outputs", {27'd0, bus.busy, bus.done, flags_now()}, 32'd0);

        // Table-driven compares.
        for (int i = 0; i < 10; i++) begin
            accept(vecs[i].a, vecs[i].b);
            wait_done(e, bc);
            chk($sformatf("lat[%0d]", i), e, exp_lat(vecs[i].lat_early));
            chk($sformatf("busy_cycles[%0d]", i), bc, exp_lat(vecs[i].lat_early) - 1);
            chk($sformatf("flags[%0d]", i), {29'd0, flags_now()}, {29'd0, vecs[i].flags});
            chk($sformatf("busy_at_done[%0d]", i), {31'd0, bus.busy}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("done_one_cycle[%0d]", i), {31'd0, bus.done}, 32'd0);
            chk($sformatf("flags_hold[%0d]", i), {29'd0, flags_now()}, {29'd0, vecs[i].flags});
        end

        // start during COMPARE with different operands must be ignored.
        accept(8'h12, 8'h13);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(e, bc);
        chk("ignored_start_lat", e + 1, 9);
        chk("ignored_start_flags", {29'd0, flags_now()}, {29'd0, 3'b010});

        // Back-to-back: start held in the DONE cycle.
        accept(8'h80, 8'h7F);
        chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
        chk("b2b_no_done", {31'd0, bus.done}, 32'd0);
        chk("b2b_flags_cleared", {29'd0, flags_now()}, 32'd0);
        wait_done(e, bc);
        chk("b2b_lat", e, exp_lat(2));
        chk("b2b_flags", {29'd0, flags_now()}, {29'd0, 3'b100});
        @(posedge clk);
        #1;

        // Asynchronous reset in the third COMPARE cycle.
        accept(8'h01, 8'h00);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", {27'd0, bus.busy, bus.done, flags_now()}, 32'd0);
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        chk("rst_no_done", done_seen, 0);
        chk("rst_idle_flags", {29'd0, flags_now()}, 32'd0);

        // Fresh compare after reset release.
        accept(8'h7F, 8'h80);
        wait_done(e, bc);
        chk("post_rst_lat", e, exp_lat(2));
        chk("post_rst_flags", {29'd0, flags_now()}, {29'd0, 3'b010});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
